// File: rtl/btb_pkg.sv
// Shared types and constants for the branch target buffer.
// Holds the 2-bit direction counter type, its reset/allocate values and the flush FSM states.
package btb_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_RESET = 2'd1;
  localparam ctr_t CTR_ALLOC = 2'd2;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/btb_sat_ctr.sv
// 2-bit saturating up/down counter, next-value logic only.
// The counter stops at 3 when incrementing and at 0 when decrementing.
module btb_sat_ctr
  import btb_pkg::*;
(
  input  ctr_t cur,
  input  logic taken,
  output ctr_t next
);

  always_comb begin
    next = cur;
    if (taken) begin
      if (cur != 2'd3) next = cur + 2'd1;
    end else begin
      if (cur != 2'd0) next = cur - 2'd1;
    end
  end

endmodule

// File: rtl/btb_table.sv
// Direct-mapped branch target buffer with a 1-cycle registered lookup,
// update/allocate on branch resolution, and a one-entry-per-cycle flush walk.
//
//   state | meaning
//   IDLE  | normal operation: lookups hit/miss, updates write the table
//   FLUSH | clearing valid[r_flush_ptr] each cycle; lookups miss, updates dropped
module btb_table
  import btb_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ENTRIES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  output logic             busy,
  input  logic             lookup_req,
  input  logic [WIDTH-1:0] lookup_pc,
  output logic             resp_valid,
  output logic             hit,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_target,
  input  logic             upd_valid,
  input  logic [WIDTH-1:0] upd_pc,
  input  logic [WIDTH-1:0] upd_target,
  input  logic             upd_taken
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = WIDTH - IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [WIDTH-1:0]   r_target [ENTRIES];
  ctr_t               r_ctr    [ENTRIES];

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_flush_ptr;
  logic             w_flush_clr;
  logic             w_upd_en;

  logic             r_resp_valid;
  logic             r_hit;
  logic             r_pred_taken;
  logic [WIDTH-1:0] r_pred_target;

  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic             w_lk_hit;
  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  logic             w_up_hit;
  ctr_t             w_ctr_next;

  assign w_lk_idx = lookup_pc[IDX_W-1:0];
  assign w_lk_tag = lookup_pc[WIDTH-1:IDX_W];
  assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

  assign w_up_idx = upd_pc[IDX_W-1:0];
  assign w_up_tag = upd_pc[WIDTH-1:IDX_W];
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

  btb_sat_ctr u_sat_ctr (
    .cur   (r_ctr[w_up_idx]),
    .taken (upd_taken),
    .next  (w_ctr_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_flush_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_flush_clr) r_flush_ptr <= r_flush_ptr + 1'b1;
    end
  end

  // Flush takes priority over a same-cycle update; the walk starts on the next edge.
  always_comb begin
    w_state_nxt = r_state;
    w_flush_clr = 1'b0;
    w_upd_en    = 1'b0;
    case (r_state)
      IDLE: begin
        if (flush) w_state_nxt = FLUSH;
        else       w_upd_en    = upd_valid;
      end
      FLUSH: begin
        w_flush_clr = 1'b1;
        if (r_flush_ptr == LAST_IDX) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign busy = (r_state == FLUSH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CTR_RESET;
      end
    end else begin
      if (w_upd_en) begin
        if (w_up_hit) begin
          r_ctr[w_up_idx] <= w_ctr_next;
          if (upd_taken) r_target[w_up_idx] <= upd_target;
        end else if (upd_taken) begin
          r_valid[w_up_idx]  <= 1'b1;
          r_tag[w_up_idx]    <= w_up_tag;
          r_target[w_up_idx] <= upd_target;
          r_ctr[w_up_idx]    <= CTR_ALLOC;
        end
      end
      if (w_flush_clr) r_valid[r_flush_ptr] <= 1'b0;
    end
  end

  // Response reads the table as it stood before this edge (read-before-write).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid  <= 1'b0;
      r_hit         <= 1'b0;
      r_pred_taken  <= 1'b0;
      r_pred_target <= '0;
    end else begin
      r_resp_valid  <= lookup_req;
      r_hit         <= 1'b0;
      r_pred_taken  <= 1'b0;
      r_pred_target <= '0;
      if (lookup_req && (r_state == IDLE) && w_lk_hit) begin
        r_hit         <= 1'b1;
        r_pred_taken  <= r_ctr[w_lk_idx][1];
        r_pred_target <= r_target[w_lk_idx];
      end
    end
  end

  assign resp_valid  = r_resp_valid;
  assign hit         = r_hit;
  assign pred_taken  = r_pred_taken;
  assign pred_target = r_pred_target;

endmodule

// File: tb/tb_btb_table.sv
// Scoreboard bench for btb_table: lookups push expected responses, a monitor pops and compares.
module tb_btb_table;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        busy;
  logic        lookup_req;
  logic [15:0] lookup_pc;
  logic        resp_valid;
  logic        hit;
  logic        pred_taken;
  logic [15:0] pred_target;
  logic        upd_valid;
  logic [15:0] upd_pc;
  logic [15:0] upd_target;
  logic        upd_taken;

  typedef struct packed {
    logic        hit;
    logic        taken;
    logic [15:0] tgt;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  btb_table #(.WIDTH(16), .ENTRIES(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .busy        (busy),
    .lookup_req  (lookup_req),
    .lookup_pc   (lookup_pc),
    .resp_valid  (resp_valid),
    .hit         (hit),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_target  (upd_target),
    .upd_taken   (upd_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cyc(input logic lr, input logic [15:0] lpc,
                     input logic uv, input logic [15:0] upc, input logic [15:0] utgt,
                     input logic ut, input logic fl,
                     input logic eh, input logic et, input logic [15:0] etgt);
    @(negedge clk);
    lookup_req = lr;
    lookup_pc  = lpc;
    upd_valid  = uv;
    upd_pc     = upc;
    upd_target = utgt;
    upd_taken  = ut;
    flush      = fl;
    if (lr) q.push_back('{hit: eh, taken: et, tgt: etgt});
  endtask

  task automatic lk(input logic [15:0] pc, input logic eh, input logic et, input logic [15:0] etgt);
    cyc(1'b1, pc, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, eh, et, etgt);
  endtask

  task automatic up(input logic [15:0] pc, input logic [15:0] tgt, input logic t);
    cyc(1'b0, 16'h0, 1'b1, pc, tgt, t, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic idle();
    cyc(1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #2;
    if (rst_n) begin
      if (resp_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("resp", {14'd0, hit, pred_taken, pred_target}, {14'd0, e.hit, e.taken, e.tgt});
        end
      end else begin
        chk("idle_outputs_zero", {14'd0, hit, pred_taken, pred_target}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; lookup_req = 1'b0; lookup_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {13'd0, busy, resp_valid, hit, pred_taken, pred_target}, 32'd0);
    rst_n = 1'b1;

    // cold miss, allocate, hit, alias miss
    lk(16'h3004, 1'b0, 1'b0, 16'h0000);
    up(16'h3004, 16'h3100, 1'b1);
    lk(16'h3004, 1'b1, 1'b1, 16'h3100);
    lk(16'h4004, 1'b0, 1'b0, 16'h0000);

    // counter walk 2->1->0->0, target kept on not-taken
    up(16'h3004, 16'hBEEF, 1'b0);
    lk(16'h3004, 1'b1, 1'b0, 16'h3100);
    up(16'h3004, 16'hBEEF, 1'b0);
    lk(16'h3004, 1'b1, 1'b0, 16'h3100);
    up(16'h3004, 16'hBEEF, 1'b0);
    lk(16'h3004, 1'b1, 1'b0, 16'h3100);
    for (int i = 0; i < 4; i++) up(16'h3004, 16'h3100, 1'b1);
    lk(16'h3004, 1'b1, 1'b1, 16'h3100);
    up(16'h3004, 16'hBEEF, 1'b0);
    lk(16'h3004, 1'b1, 1'b1, 16'h3100);
    up(16'h3004, 16'hBEEF, 1'b0);
    lk(16'h3004, 1'b1, 1'b0, 16'h3100);

    // same-cycle lookup + update returns old contents
    up(16'h3005, 16'h3150, 1'b1);
    lk(16'h3005, 1'b1, 1'b1, 16'h3150);
    cyc(1'b1, 16'h3005, 1'b1, 16'h3005, 16'h3200, 1'b1, 1'b0, 1'b1, 1'b1, 16'h3150);
    lk(16'h3005, 1'b1, 1'b1, 16'h3200);

    // not-taken miss does not allocate
    up(16'h7007, 16'h1234, 1'b0);
    lk(16'h7007, 1'b0, 1'b0, 16'h0000);

    // fill, then flush with a colliding update
    for (int i = 0; i < 16; i++) up(16'h1000 | 16'(i), 16'h2000 + 16'(i), 1'b1);
    lk(16'h100F, 1'b1, 1'b1, 16'h200F);
    cyc(1'b1, 16'h1003, 1'b1, 16'h5000, 16'h5555, 1'b1, 1'b1, 1'b1, 1'b1, 16'h2003);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 16'h1000 | 16'(i), 1'b1, 16'h6000, 16'h6666, 1'b1, (i == 15),
          1'b0, 1'b0, 16'h0000);
      chk("busy_during_walk", {31'd0, busy}, 32'd1);
    end
    lk(16'h1000, 1'b0, 1'b0, 16'h0000);
    chk("busy_after_walk", {31'd0, busy}, 32'd0);
    for (int i = 1; i < 16; i++) lk(16'h1000 | 16'(i), 1'b0, 1'b0, 16'h0000);
    lk(16'h6000, 1'b0, 1'b0, 16'h0000);
    lk(16'h5000, 1'b0, 1'b0, 16'h0000);

    // reset in flush cycle 5
    up(16'h1001, 16'h2001, 1'b1);
    lk(16'h1001, 1'b1, 1'b1, 16'h2001);
    cyc(1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    repeat (4) idle();
    @(negedge clk);
    chk("busy_before_abort", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy_resp", {30'd0, busy, resp_valid}, 32'd0);
    lk(16'h1001, 1'b0, 1'b0, 16'h0000);
    idle();
    chk("idle_after_abort", {31'd0, busy}, 32'd0);

    repeat (3) idle();
    chk("queue_drained", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
